// File: rtl/pc_sequencer_if.sv
// Control/status bundle between a fetch controller and the PC sequencer.
// The controller drives the request side (master); the sequencer answers (slave).
interface pc_sequencer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  logic                       stall;
  logic                       exc_valid;
  logic                       redirect_valid;
  logic [WIDTH-1:0]           redirect_target;
  logic                       call;
  logic                       ret;
  logic [WIDTH-1:0]           pc;
  logic [WIDTH-1:0]           pc_next_seq;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic                       ret_miss;
  logic                       misalign;

  modport master (
    output stall, exc_valid, redirect_valid, redirect_target, call, ret,
    input  pc, pc_next_seq, ras_count, ret_miss, misalign
  );

  modport slave (
    input  stall, exc_valid, redirect_valid, redirect_target, call, ret,
    output pc, pc_next_seq, ras_count, ret_miss, misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority next-PC select (exception, redirect, return, stall,
// sequential) with a circular return-address stack that overwrites its oldest entry when full.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h0000_3180,
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned     PtrW   = $clog2(RAS_DEPTH);
  localparam int unsigned     CntW   = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PtrW-1:0]  r_top;
  logic [CntW-1:0]  r_count;
  logic             r_ret_miss;
  logic             r_misalign;

  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_pc_d;
  logic [WIDTH-1:0] w_target_aligned;
  logic             w_ras_nonempty;
  logic             w_push;
  logic             w_pop;
  logic             w_ret_miss;
  logic             w_misalign;
  logic             w_ras_we;
  logic [PtrW-1:0]  w_ras_widx;
  logic [PtrW-1:0]  w_top_d;
  logic [CntW-1:0]  w_count_d;

  assign w_pc_seq         = r_pc + WIDTH'(STEP);
  assign w_target_aligned = {bus.redirect_target[WIDTH-1:2], 2'b00};
  assign w_ras_nonempty   = (r_count != '0);

  // Accept conditions follow the same priority as the PC select below.
  assign w_push     = bus.call & bus.redirect_valid & ~bus.exc_valid;
  assign w_pop      = bus.ret & ~bus.exc_valid & ~bus.redirect_valid & w_ras_nonempty;
  assign w_ret_miss = bus.ret & ~bus.exc_valid & ~bus.redirect_valid & ~w_ras_nonempty;
  assign w_misalign = bus.redirect_valid & ~bus.exc_valid & (bus.redirect_target[1:0] != 2'b00);

  always_comb begin
    w_pc_d = w_pc_seq;
    if (bus.exc_valid) begin
      w_pc_d = EXC_VECTOR;
    end else if (bus.redirect_valid) begin
      w_pc_d = w_target_aligned;
    end else if (bus.ret && w_ras_nonempty) begin
      w_pc_d = r_ras[r_top];
    end else if (bus.stall) begin
      w_pc_d = r_pc;
    end
  end

  // Stack pointer always names the top entry; a wrapping push silently drops the oldest.
  always_comb begin
    w_ras_we   = 1'b0;
    w_ras_widx = r_top + PtrW'(1);
    w_top_d    = r_top;
    w_count_d  = r_count;
    if (w_push && w_pop) begin
      w_ras_we   = 1'b1;
      w_ras_widx = r_top;
    end else if (w_push) begin
      w_ras_we  = 1'b1;
      w_top_d   = r_top + PtrW'(1);
      w_count_d = (r_count == CntMax) ? r_count : r_count + CntW'(1);
    end else if (w_pop) begin
      w_top_d   = r_top - PtrW'(1);
      w_count_d = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_top      <= '0;
      r_count    <= '0;
      r_ret_miss <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_d;
      r_top      <= w_top_d;
      r_count    <= w_count_d;
      r_ret_miss <= w_ret_miss;
      r_misalign <= w_misalign;
    end
  end

  // Entries are left unreset; ras_count alone defines which are valid.
  always_ff @(posedge clk) begin
    if (!reset && w_ras_we) begin
      r_ras[w_ras_widx] <= w_pc_seq;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pc_next_seq = w_pc_seq;
  assign bus.ras_count   = r_count;
  assign bus.ret_miss    = r_ret_miss;
  assign bus.misalign    = r_misalign;

endmodule
